// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared constants for the packet-level UART TX arbiter.
// FSM state encodings, CRC-8 parameters (used only when UART_TX_ARB_CRC_EN
// is defined) and the width of the stall watchdog counter.
package uart_tx_arb_pkg;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE      = 3'd0;
    localparam arb_state_t ST_WAIT_BYTE = 3'd1;
    localparam arb_state_t ST_SEND      = 3'd2;
    localparam arb_state_t ST_GUARD     = 3'd3;
    localparam arb_state_t ST_WAIT_TX   = 3'd4;
    localparam arb_state_t ST_CRC_SEND  = 3'd5;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // Wide enough for the default 1_000_000-cycle timeout with headroom.
    localparam int WDOG_W = 32;

endpackage

// File: rtl/uart_tx_arbiter_crc8_step.sv
// crc8_step: combinational one-byte CRC-8 update (poly 0x07, MSB-first,
// no reflection). Only compiled when UART_TX_ARB_CRC_EN is defined, since
// the arbiter instantiates it only in that build.
`ifdef UART_TX_ARB_CRC_EN
module crc8_step
    import uart_tx_arb_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] work;

    // Fold the byte into the register, then run eight polynomial shifts.
    always_comb begin
        work = crc_in ^ data_in;
        for (int b = 0; b < 8; b++) begin
            if (work[7]) begin
                work = {work[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                work = {work[6:0], 1'b0};
            end
        end
        crc_out = work;
    end

endmodule
`endif

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: merges N_SRC byte-stream packet sources onto one uart_tx.
// Round-robin grant at packet granularity, valid/ready byte handshake,
// uart_tx busy pacing and a stall watchdog that aborts a silent packet.
// Optional feature: define UART_TX_ARB_CRC_EN to append a CRC-8 byte to
// every completed packet.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_SRC       = 2,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int IDX_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*N_SRC-1:0]   src_data,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [N_SRC-1:0]     src_last,
    output logic [N_SRC-1:0]     src_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    input  logic                 tx_busy,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 active,
    output logic                 timeout_err,
    output logic [15:0]          pkt_count
);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               active_q, active_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               last_q, last_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               timeout_q, timeout_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;

    logic [IDX_W-1:0]   rr_cand;
    logic [IDX_W-1:0]   rr_pick;
    logic               rr_found;
    logic [7:0]         g_data;
    logic               accept;
    logic               pkt_done;

`ifdef UART_TX_ARB_CRC_EN
    logic [7:0]         crc_q, crc_d;
    logic               crc_phase_q, crc_phase_d;
    logic [7:0]         crc_next;

    crc8_step u_crc8_step (
        .crc_in  (crc_q),
        .data_in (g_data),
        .crc_out (crc_next)
    );
`endif

    // Round-robin search starting after the last grant; walking offsets from
    // farthest to nearest leaves the nearest requester as the final pick.
    always_comb begin
        rr_cand  = grant_q;
        rr_pick  = grant_q;
        rr_found = 1'b0;
        for (int off = N_SRC; off >= 1; off--) begin
            rr_cand = IDX_W'((int'(grant_q) + off) % N_SRC);
            if (src_valid[rr_cand]) begin
                rr_pick  = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    assign g_data    = src_data[{grant_q, 3'b000} +: 8];
    assign accept    = (state_q == ST_WAIT_BYTE) && src_valid[grant_q] && !tx_busy;
    assign src_ready = accept ? (N_SRC'(1) << grant_q) : '0;
    assign tx_send   = (state_q == ST_SEND);

    assign tx_data     = tx_data_q;
    assign grant_idx   = grant_q;
    assign active      = active_q;
    assign timeout_err = timeout_q;
    assign pkt_count   = pkt_cnt_q;

    // Packet FSM: grant, per-byte handshake, send pacing, watchdog and wrap-up.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        active_d  = active_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
        pkt_cnt_d = pkt_cnt_q;
        pkt_done  = 1'b0;
`ifdef UART_TX_ARB_CRC_EN
        crc_d       = crc_q;
        crc_phase_d = crc_phase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d  = rr_pick;
                    active_d = 1'b1;
                    wdog_d   = '0;
                    state_d  = ST_WAIT_BYTE;
`ifdef UART_TX_ARB_CRC_EN
                    crc_d       = CRC8_INIT;
                    crc_phase_d = 1'b0;
`endif
                end
            end
            ST_WAIT_BYTE: begin
                if (accept) begin
                    tx_data_d = g_data;
                    last_d    = src_last[grant_q];
                    wdog_d    = '0;
                    state_d   = ST_SEND;
`ifdef UART_TX_ARB_CRC_EN
                    crc_d = crc_next;
`endif
                end else if (!src_valid[grant_q] && (TIMEOUT_CYC != 0)) begin
                    // Abort: grant_q already holds g, so the pointer advances past it.
                    if (wdog_q == WDOG_W'(TIMEOUT_CYC - 1)) begin
                        timeout_d = 1'b1;
                        active_d  = 1'b0;
                        wdog_d    = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            ST_SEND: begin
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (!tx_busy) begin
                    if (!last_q) begin
                        state_d = ST_WAIT_BYTE;
                    end else begin
`ifdef UART_TX_ARB_CRC_EN
                        if (crc_phase_q) begin
                            pkt_done = 1'b1;
                        end else begin
                            state_d = ST_CRC_SEND;
                        end
`else
                        pkt_done = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_TX_ARB_CRC_EN
            ST_CRC_SEND: begin
                tx_data_d   = crc_q;
                crc_phase_d = 1'b1;
                state_d     = ST_SEND;
            end
`endif
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase
        if (pkt_done) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            active_d  = 1'b0;
            state_d   = ST_IDLE;
        end
    end

    // Control and data registers; reset drops any packet in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= IDX_W'(N_SRC - 1);
            active_q  <= 1'b0;
            tx_data_q <= 8'h00;
            last_q    <= 1'b0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            pkt_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            active_q  <= active_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

`ifdef UART_TX_ARB_CRC_EN
    // Running CRC of the granted packet and the flag marking its CRC byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q       <= CRC8_INIT;
            crc_phase_q <= 1'b0;
        end else begin
            crc_q       <= crc_d;
            crc_phase_q <= crc_phase_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with three sources,
// a 16-cycle watchdog and a uart_tx model that stays busy for 10 cycles per
// byte. With UART_TX_ARB_CRC_EN defined it also exercises the CRC byte.
module tb_uart_tx_arbiter;

    localparam int N        = 3;
    localparam int BUSY_CYC = 10;
`ifdef UART_TX_ARB_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [8*N-1:0] src_data;
    logic [N-1:0]  src_valid;
    logic [N-1:0]  src_last;
    logic [N-1:0]  src_ready;
    logic [7:0]    tx_data;
    logic          tx_send;
    logic          tx_busy;
    logic [1:0]    grant_idx;
    logic          active;
    logic          timeout_err;
    logic [15:0]   pkt_count;

    uart_tx_arbiter #(.N_SRC(N), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_busy     (tx_busy),
        .grant_idx   (grant_idx),
        .active      (active),
        .timeout_err (timeout_err),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    // Source memories and write pointers (main only); read pointers (env only).
    logic [8:0] mem [N][128];
    int         wr [N];
    int         rd [N];
    bit         flush_req;

    // Monitor state (env only).
    logic [9:0] log_e [512];
    int         log_n, cyc, busy_cnt, to_cnt, to_cyc, busy_fall, viol;
    int         valid_rise, ready_rise, send_rise;

    // Expected transmit log (main only).
    logic [9:0] exp_e [512];
    int         exp_n, log_chk;
    int         checks, errors;

    function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_pkt(input int s, input int n, input logic [7:0] base, input bit term);
        for (int k = 0; k < n; k++) begin
            mem[s][wr[s] + k] = {(term && (k == n - 1)), base + 8'(k)};
        end
        wr[s] = wr[s] + n;
    endtask

    task automatic exp_pkt(input int s, input int n, input logic [7:0] base, input bit with_crc);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h00;
        for (int k = 0; k < n; k++) begin
            b = base + 8'(k);
            exp_e[exp_n] = {2'(s), b};
            exp_n++;
            c = crc8_ref(c, b);
        end
        if (CRC_ON && with_crc) begin
            exp_e[exp_n] = {2'(s), c};
            exp_n++;
        end
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_len"}, 32'(log_n), 32'(exp_n));
        for (int i = log_chk; i < exp_n; i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(log_e[i]), 32'(exp_e[i]));
        end
        log_chk = exp_n;
    endtask

    task automatic wait_done(input string tag);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            done = (rd[0] == wr[0]) && (rd[1] == wr[1]) && (rd[2] == wr[2]) && !active && !tx_busy;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush_req = 1'b1;
        repeat (3) @(negedge clk);
        flush_req = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
    endtask

    // Environment: source queues, uart_tx busy model and transmit monitor.
    initial begin : env
        logic [N-1:0] take;
        bit           send_seen, prev_busy, rdy_pend, snd_pend;
        logic [N-1:0] prev_valid;
        src_valid = '0; src_last = '0; src_data = '0; tx_busy = 1'b0;
        log_n = 0; cyc = 0; busy_cnt = 0; to_cnt = 0; to_cyc = -1; busy_fall = -1; viol = 0;
        valid_rise = -1; ready_rise = -1; send_rise = -1;
        prev_busy = 1'b0; prev_valid = '0; rdy_pend = 1'b0; snd_pend = 1'b0;
        for (int i = 0; i < N; i++) rd[i] = 0;
        forever begin
            @(negedge clk);
            take      = src_ready & src_valid;
            send_seen = tx_send;
            if (tx_send && log_n < 512) begin
                log_e[log_n] = {grant_idx, tx_data};
                log_n++;
            end
            if (src_valid != 0 && prev_valid == 0) begin
                valid_rise = cyc; rdy_pend = 1'b1; snd_pend = 1'b1;
            end
            if (rdy_pend && src_ready != 0) begin ready_rise = cyc; rdy_pend = 1'b0; end
            if (snd_pend && tx_send)        begin send_rise  = cyc; snd_pend = 1'b0; end
            prev_valid = src_valid;
            if (timeout_err) begin to_cnt++; to_cyc = cyc; end
            if (prev_busy && !tx_busy) busy_fall = cyc;
            prev_busy = tx_busy;
            if ($countones(src_ready) > 1) viol++;
            if (active && ((src_ready & ~(N'(1) << grant_idx)) != 0)) viol++;
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < N; i++) begin
                if (flush_req) rd[i] = wr[i];
                else if (take[i]) rd[i] = rd[i] + 1;
            end
            if (send_seen) busy_cnt = BUSY_CYC;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = (busy_cnt != 0);
            for (int i = 0; i < N; i++) begin
                if (rd[i] < wr[i]) begin
                    src_valid[i]       = 1'b1;
                    src_data[8*i +: 8] = mem[i][rd[i]][7:0];
                    src_last[i]        = mem[i][rd[i]][8];
                end else begin
                    src_valid[i] = 1'b0;
                    src_last[i]  = 1'b0;
                end
            end
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int base, to_base, v_base;
        checks = 0; errors = 0; exp_n = 0; log_chk = 0; flush_req = 1'b0; rst_n = 1'b0;
        for (int i = 0; i < N; i++) wr[i] = 0;

        // Reset values.
        do_reset();
        check_eq("rst_ready",   32'(src_ready),   32'd0);
        check_eq("rst_send",    32'(tx_send),     32'd0);
        check_eq("rst_data",    32'(tx_data),     32'd0);
        check_eq("rst_grant",   32'(grant_idx),   32'd2);
        check_eq("rst_active",  32'(active),      32'd0);
        check_eq("rst_timeout", 32'(timeout_err), 32'd0);
        check_eq("rst_pktcnt",  32'(pkt_count),   32'd0);

        // Single request from source 0: ready one cycle, send two cycles after valid.
        push_pkt(0, 1, 8'hCC, 1'b1);
        exp_pkt(0, 1, 8'hCC, 1'b1);
        wait_done("single");
        check_eq("single_ready_lat", 32'(ready_rise - valid_rise), 32'd1);
        check_eq("single_send_lat",  32'(send_rise - valid_rise),  32'd2);
        check_log("single");
        check_eq("single_pktcnt", 32'(pkt_count), 32'd1);
        check_eq("single_active", 32'(active), 32'd0);

        // Round-robin: simultaneous requests, source 0 has a second packet queued.
        do_reset();
        push_pkt(0, 2, 8'h10, 1'b1);
        push_pkt(0, 2, 8'h40, 1'b1);
        push_pkt(1, 2, 8'h20, 1'b1);
        push_pkt(2, 2, 8'h30, 1'b1);
        exp_pkt(0, 2, 8'h10, 1'b1);
        exp_pkt(1, 2, 8'h20, 1'b1);
        exp_pkt(2, 2, 8'h30, 1'b1);
        exp_pkt(0, 2, 8'h40, 1'b1);
        v_base = viol;
        wait_done("rr");
        check_log("rr");
        check_eq("rr_pktcnt", 32'(pkt_count), 32'd4);

        // Contention: source 0 requests while source 1 is mid-packet.
        base = log_n;
        push_pkt(1, 40, 8'h80, 1'b1);
        exp_pkt(1, 40, 8'h80, 1'b1);
        for (int n = 0; n < 3000 && (log_n - base) < 5; n++) @(negedge clk);
        check_eq("cont_started", 32'((log_n - base) >= 5), 32'd1);
        push_pkt(0, 2, 8'h50, 1'b1);
        exp_pkt(0, 2, 8'h50, 1'b1);
        wait_done("cont");
        check_log("cont");
        check_eq("cont_ready_excl", 32'(viol - v_base), 32'd0);
        check_eq("cont_pktcnt", 32'(pkt_count), 32'd6);

        // Watchdog: one non-final byte, then the source goes silent.
        to_base = to_cnt;
        push_pkt(0, 1, 8'h5A, 1'b0);
        exp_pkt(0, 1, 8'h5A, 1'b0);
        wait_done("wdog");
        check_log("wdog");
        check_eq("wdog_pulses", 32'(to_cnt - to_base), 32'd1);
        check_eq("wdog_delay",  32'(to_cyc - busy_fall), 32'd17);
        check_eq("wdog_pktcnt", 32'(pkt_count), 32'd6);
        check_eq("wdog_active", 32'(active), 32'd0);
        check_eq("wdog_err_low", 32'(timeout_err), 32'd0);

`ifdef UART_TX_ARB_CRC_EN
        // CRC byte appended after each completed packet.
        base = log_n;
        push_pkt(0, 1, 8'h01, 1'b1);
        push_pkt(0, 2, 8'h01, 1'b1);
        exp_pkt(0, 1, 8'h01, 1'b1);
        exp_pkt(0, 2, 8'h01, 1'b1);
        wait_done("crc");
        check_log("crc");
        check_eq("crc_single", 32'(log_e[base + 1][7:0]), 32'h07);
        check_eq("crc_pair",   32'(log_e[base + 4][7:0]), 32'h1B);
        check_eq("crc_pktcnt", 32'(pkt_count), 32'd8);
`endif

        // Reset mid-packet while waiting on uart_tx.
        base = log_n;
        push_pkt(1, 3, 8'h61, 1'b1);
        exp_e[exp_n] = {2'd1, 8'h61};
        exp_n++;
        for (int n = 0; n < 3000 && log_n == base; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready",  32'(src_ready), 32'd0);
        check_eq("mid_rst_send",   32'(tx_send),   32'd0);
        check_eq("mid_rst_data",   32'(tx_data),   32'd0);
        check_eq("mid_rst_grant",  32'(grant_idx), 32'd2);
        check_eq("mid_rst_active", 32'(active),    32'd0);
        check_eq("mid_rst_pktcnt", 32'(pkt_count), 32'd0);
        flush_req = 1'b1;
        repeat (2) @(negedge clk);
        flush_req = 1'b0;
        rst_n     = 1'b1;
        push_pkt(1, 1, 8'h71, 1'b1);
        push_pkt(0, 1, 8'h70, 1'b1);
        exp_pkt(0, 1, 8'h70, 1'b1);
        exp_pkt(1, 1, 8'h71, 1'b1);
        wait_done("post_rst");
        check_log("post_rst");
        check_eq("post_rst_pktcnt", 32'(pkt_count), 32'd2);
        check_eq("post_rst_grant",  32'(grant_idx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
